// File: rtl/alu_result_stage.sv
// ALU result stage: combines LHS with the registered RHS logic value,
// registers the result, valid bit and {V,N,C,Z} flags.
module alu_result_stage (
    input  logic       AluClock,
    input  logic       Reset,
    input  logic [7:0] LHS,
    input  logic [7:0] Logic,
    input  logic [2:0] AluOp,
    input  logic       InValid,
    input  logic       Hold,
    input  logic       FlagsWrite,
    input  logic       FlagsLoad,
    input  logic [3:0] FlagsIn,
    output logic [7:0] Result,
    output logic       ResultValid,
    output logic [3:0] Flags
);

    typedef enum logic [2:0] {
        OP_PASS = 3'b000,
        OP_ADD  = 3'b001,
        OP_ADC  = 3'b010,
        OP_SUB  = 3'b011,
        OP_SBC  = 3'b100,
        OP_SHL  = 3'b101,
        OP_SHR  = 3'b110,
        OP_ROR  = 3'b111
    } alu_op_e;

    logic [7:0] r_result;
    logic       r_valid;
    logic [3:0] r_flags;

    logic       w_cf;
    logic       w_cin;
    logic [8:0] w_sum;
    logic [7:0] w_r;
    logic       w_c;
    logic       w_v;
    logic       w_arith;
    logic [3:0] w_flags;

    assign w_cf = r_flags[1];

    // Carry-in of the shared adder; SUB relies on upstream RHS inversion.
    always_comb begin
        w_cin   = 1'b0;
        w_arith = 1'b0;
        case (alu_op_e'(AluOp))
            OP_ADD: w_arith = 1'b1;
            OP_ADC: begin w_arith = 1'b1; w_cin = w_cf; end
            OP_SUB: begin w_arith = 1'b1; w_cin = 1'b1; end
            OP_SBC: begin w_arith = 1'b1; w_cin = w_cf; end
            default: ;
        endcase
    end

    assign w_sum = {1'b0, LHS} + {1'b0, Logic} + {8'd0, w_cin};

    always_comb begin
        w_r = Logic;
        w_c = 1'b0;
        case (alu_op_e'(AluOp))
            OP_PASS: begin w_r = Logic; w_c = 1'b0; end
            OP_SHL:  begin w_r = {Logic[6:0], 1'b0}; w_c = Logic[7]; end
            OP_SHR:  begin w_r = {1'b0, Logic[7:1]}; w_c = Logic[0]; end
            OP_ROR:  begin w_r = {w_cf, Logic[7:1]}; w_c = Logic[0]; end
            default: begin w_r = w_sum[7:0]; w_c = w_sum[8]; end
        endcase
    end

    assign w_v = w_arith && (LHS[7] == Logic[7]) && (w_r[7] != LHS[7]);
    assign w_flags = {w_v, w_r[7], w_c, (w_r == 8'd0)};

    always_ff @(posedge AluClock or posedge Reset) begin
        if (Reset) begin
            r_result <= 8'd0;
            r_valid  <= 1'b0;
            r_flags  <= 4'd0;
        end else if (!Hold) begin
            r_valid <= InValid;
            if (InValid)
                r_result <= w_r;
            if (FlagsLoad)
                r_flags <= FlagsIn;
            else if (InValid && FlagsWrite)
                r_flags <= w_flags;
        end
    end

    assign Result      = r_result;
    assign ResultValid = r_valid;
    assign Flags       = r_flags;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage with hand-computed expectations.
module tb_alu_result_stage;

    logic       AluClock = 1'b0;
    logic       Reset;
    logic [7:0] LHS;
    logic [7:0] Logic;
    logic [2:0] AluOp;
    logic       InValid;
    logic       Hold;
    logic       FlagsWrite;
    logic       FlagsLoad;
    logic [3:0] FlagsIn;
    logic [7:0] Result;
    logic       ResultValid;
    logic [3:0] Flags;

    int checks = 0;
    int failures = 0;

    alu_result_stage dut (
        .AluClock   (AluClock),
        .Reset      (Reset),
        .LHS        (LHS),
        .Logic      (Logic),
        .AluOp      (AluOp),
        .InValid    (InValid),
        .Hold       (Hold),
        .FlagsWrite (FlagsWrite),
        .FlagsLoad  (FlagsLoad),
        .FlagsIn    (FlagsIn),
        .Result     (Result),
        .ResultValid(ResultValid),
        .Flags      (Flags)
    );

    always #5 AluClock = ~AluClock;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] r,
                           input logic v, input logic [3:0] f);
        chk({tag, ".result"}, Result, r);
        chk({tag, ".valid"}, {7'd0, ResultValid}, {7'd0, v});
        chk({tag, ".flags"}, {4'd0, Flags}, {4'd0, f});
    endtask

    task automatic drive(input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic iv,
                         input logic fw);
        AluOp = op; LHS = a; Logic = b; InValid = iv; FlagsWrite = fw;
    endtask

    task automatic step;
        @(posedge AluClock);
        #1;
    endtask

    initial begin
        Reset = 1'b1; Hold = 1'b0; FlagsLoad = 1'b0; FlagsIn = 4'd0;
        drive(3'b000, 8'h00, 8'h00, 1'b0, 1'b0);
        #1;
        chk_all("reset_async", 8'h00, 1'b0, 4'h0);
        step;
        Hold = 1'b1;
        drive(3'b001, 8'h12, 8'h34, 1'b1, 1'b1);
        step;
        chk_all("reset_hold", 8'h00, 1'b0, 4'h0);
        Hold = 1'b0;
        Reset = 1'b0;
        drive(3'b000, 8'h00, 8'h00, 1'b0, 1'b0);
        step;

        // ADD overflow into sign bit
        drive(3'b001, 8'h7F, 8'h01, 1'b1, 1'b1);
        step;
        chk_all("add_ovf", 8'h80, 1'b1, 4'hC);

        // SUB equal operands, no borrow
        drive(3'b011, 8'h05, 8'hFA, 1'b1, 1'b1);
        step;
        chk_all("sub_eq", 8'h00, 1'b1, 4'h3);

        // chained carry
        drive(3'b001, 8'hFF, 8'h01, 1'b1, 1'b1);
        step;
        chk_all("add_carry", 8'h00, 1'b1, 4'h3);
        drive(3'b010, 8'h00, 8'h00, 1'b1, 1'b1);
        step;
        chk_all("adc_chain", 8'h01, 1'b1, 4'h0);

        // Hold with changing inputs
        Hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(3'(i + 1), 8'(8'h40 + i), 8'(8'hC3 - i), i[0], 1'b1);
            FlagsLoad = i[1];
            FlagsIn = 4'hF;
            step;
            chk_all($sformatf("hold%0d", i), 8'h01, 1'b1, 4'h0);
        end
        Hold = 1'b0;
        FlagsLoad = 1'b0;

        // FlagsLoad overrides the computed update
        drive(3'b001, 8'h10, 8'h20, 1'b1, 1'b1);
        FlagsLoad = 1'b1; FlagsIn = 4'hA;
        step;
        chk_all("flags_load", 8'h30, 1'b1, 4'hA);
        FlagsLoad = 1'b0;

        // ROR with Cf=1
        drive(3'b111, 8'h00, 8'h02, 1'b1, 1'b1);
        step;
        chk_all("ror_cf1", 8'h81, 1'b1, 4'h4);

        // bubble: result retained, valid drops
        drive(3'b001, 8'h99, 8'h99, 1'b0, 1'b1);
        step;
        chk_all("bubble", 8'h81, 1'b0, 4'h4);

        // SHL without flag write
        drive(3'b101, 8'h00, 8'h81, 1'b1, 1'b0);
        step;
        chk_all("shl_nofw", 8'h02, 1'b1, 4'h4);

        // SHR to zero
        drive(3'b110, 8'h00, 8'h01, 1'b1, 1'b1);
        step;
        chk_all("shr_zero", 8'h00, 1'b1, 4'h3);

        // PASS clears C
        drive(3'b000, 8'h00, 8'h80, 1'b1, 1'b1);
        step;
        chk_all("pass", 8'h80, 1'b1, 4'h4);

        // SBC with Cf=0: 0x80 + 0x7F -> 0xFF, no overflow
        drive(3'b100, 8'h80, 8'h7F, 1'b1, 1'b1);
        step;
        chk_all("sbc_cf0", 8'hFF, 1'b1, 4'h4);

        // ADD negative overflow with wrap
        drive(3'b001, 8'h80, 8'h80, 1'b1, 1'b1);
        step;
        chk_all("add_negovf", 8'h00, 1'b1, 4'hB);

        // mid-operation reset
        drive(3'b001, 8'h11, 8'h22, 1'b1, 1'b1);
        #2;
        Reset = 1'b1;
        #1;
        chk_all("midreset", 8'h00, 1'b0, 4'h0);
        drive(3'b000, 8'h00, 8'h00, 1'b0, 1'b1);
        #1;
        Reset = 1'b0;
        step;
        chk_all("post_reset", 8'h00, 1'b0, 4'h0);
        drive(3'b001, 8'h01, 8'h01, 1'b1, 1'b1);
        step;
        chk_all("post_reset_op", 8'h02, 1'b1, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
